// File: rtl/register_file_mp.sv
// register_file_mp: multi-read-port register file with a pending-write scoreboard.
// Register 0 is hardwired to zero. Reads are registered and take one cycle.
// A same-cycle write is forwarded to the read ports.
// A busy bit per register tracks issued-but-not-yet-written destinations.
module register_file_mp #(
  parameter int DATA_WIDTH   = 32,
  parameter int REG_WIDTH    = 5,
  parameter int NUM_RD_PORTS = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rd_en,
  input  logic [REG_WIDTH-1:0]             rd,
  input  logic [DATA_WIDTH-1:0]            rd_din,
  input  logic [NUM_RD_PORTS-1:0]          rs_en,
  input  logic [NUM_RD_PORTS*REG_WIDTH-1:0] rs_addr,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rs_dout,
  output logic [NUM_RD_PORTS-1:0]          rs_valid,
  output logic [NUM_RD_PORTS-1:0]          rs_busy,
  input  logic                             issue_en,
  input  logic [REG_WIDTH-1:0]             issue_rd,
  output logic [REG_WIDTH:0]               busy_count
);

  localparam int DEPTH = 2 ** REG_WIDTH;

  logic [DATA_WIDTH-1:0]              mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]              mem_d [DEPTH];
  logic [DEPTH-1:0]                   busy_q, busy_d;
  logic [REG_WIDTH:0]                 busy_count_q, busy_count_d;
  logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rs_dout_q, rs_dout_d;
  logic [NUM_RD_PORTS-1:0]            rs_valid_q, rs_valid_d;
  logic [NUM_RD_PORTS-1:0]            rs_busy_q, rs_busy_d;

  logic wr_hit;
  logic iss_hit;

  assign wr_hit  = rd_en && (rd != '0);
  assign iss_hit = issue_en && (issue_rd != '0);

  // Next-state for storage and scoreboard; issue is applied after the write so set wins.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (wr_hit) begin
      mem_d[rd]  = rd_din;
      busy_d[rd] = 1'b0;
    end
    if (iss_hit) begin
      busy_d[issue_rd] = 1'b1;
    end
    mem_d[0]  = '0;
    busy_d[0] = 1'b0;
  end

  // Population count of the next busy vector, so busy_count tracks busy bits exactly.
  always_comb begin
    busy_count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_count_d = busy_count_d + {{REG_WIDTH{1'b0}}, busy_d[i]};
    end
  end

  // Read ports: forward same-cycle write data and mask busy for the register being written.
  always_comb begin
    rs_dout_d  = rs_dout_q;
    rs_busy_d  = rs_busy_q;
    rs_valid_d = '0;
    for (int k = 0; k < NUM_RD_PORTS; k++) begin
      logic [REG_WIDTH-1:0] idx;
      logic                 fwd;
      idx = rs_addr[k*REG_WIDTH +: REG_WIDTH];
      fwd = wr_hit && (rd == idx);
      if (rs_en[k]) begin
        rs_valid_d[k] = 1'b1;
        if (idx == '0) begin
          rs_dout_d[k*DATA_WIDTH +: DATA_WIDTH] = '0;
        end else if (fwd) begin
          rs_dout_d[k*DATA_WIDTH +: DATA_WIDTH] = rd_din;
        end else begin
          rs_dout_d[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[idx];
        end
        rs_busy_d[k] = busy_q[idx] & ~fwd;
      end
    end
  end

  // State registers; reset clears storage, scoreboard and all read outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q       <= '0;
      busy_count_q <= '0;
      rs_dout_q    <= '0;
      rs_valid_q   <= '0;
      rs_busy_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
      rs_dout_q    <= rs_dout_d;
      rs_valid_q   <= rs_valid_d;
      rs_busy_q    <= rs_busy_d;
    end
  end

  assign rs_dout    = rs_dout_q;
  assign rs_valid   = rs_valid_q;
  assign rs_busy    = rs_busy_q;
  assign busy_count = busy_count_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp with hand-computed expectations.
module tb_register_file_mp;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic [4:0]  rd;
  logic [31:0] rd_din;
  logic [1:0]  rs_en;
  logic [9:0]  rs_addr;
  logic [63:0] rs_dout;
  logic [1:0]  rs_valid;
  logic [1:0]  rs_busy;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic [5:0]  busy_count;

  int checks;
  int errors;

  register_file_mp #(.DATA_WIDTH(32), .REG_WIDTH(5), .NUM_RD_PORTS(2)) dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .rd(rd), .rd_din(rd_din),
    .rs_en(rs_en), .rs_addr(rs_addr),
    .rs_dout(rs_dout), .rs_valid(rs_valid), .rs_busy(rs_busy),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .busy_count(busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rd_en = 1'b0; rd = '0; rd_din = '0;
    rs_en = '0; rs_addr = '0;
    issue_en = 1'b0; issue_rd = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_ports(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1);
    rs_en = en;
    rs_addr = {a1, a0};
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    rst = 1'b1;
    #22;
    check("rst_dout", rs_dout, 64'h0);
    check("rst_valid", {62'h0, rs_valid}, 64'h0);
    check("rst_busy", {62'h0, rs_busy}, 64'h0);
    check("rst_count", {58'h0, busy_count}, 64'h0);
    rst = 1'b0;
    tick();

    // read x5 on both ports after reset
    rd_ports(2'b11, 5'd5, 5'd5);
    tick();
    check("x5_dout", rs_dout, 64'h0);
    check("x5_valid", {62'h0, rs_valid}, 64'h3);
    check("x5_busy", {62'h0, rs_busy}, 64'h0);
    check("x5_count", {58'h0, busy_count}, 64'h0);
    idle();
    tick();
    check("idle_valid", {62'h0, rs_valid}, 64'h0);

    // write x3 with same-cycle read on port 0: bypass
    rd_en = 1'b1; rd = 5'd3; rd_din = 32'hDEADBEEF;
    rd_ports(2'b01, 5'd3, 5'd0);
    tick();
    check("byp_dout", rs_dout, 64'h00000000_DEADBEEF);
    check("byp_valid", {62'h0, rs_valid}, 64'h1);
    idle();
    rd_ports(2'b01, 5'd3, 5'd0);
    tick();
    check("x3_reread", rs_dout, 64'h00000000_DEADBEEF);

    // write x6 while port0 reads x3 (old contents) and port1 reads x6 (bypass)
    idle();
    rd_en = 1'b1; rd = 5'd6; rd_din = 32'h0000CAFE;
    rd_ports(2'b11, 5'd3, 5'd6);
    tick();
    check("mix_dout", rs_dout, 64'h0000CAFE_DEADBEEF);

    // both ports on the same index
    idle();
    rd_ports(2'b11, 5'd6, 5'd6);
    tick();
    check("same_idx", rs_dout, 64'h0000CAFE_0000CAFE);

    // x0 write/issue ignored
    idle();
    rd_en = 1'b1; rd = 5'd0; rd_din = 32'h1234;
    issue_en = 1'b1; issue_rd = 5'd0;
    tick();
    idle();
    rd_ports(2'b11, 5'd0, 5'd0);
    tick();
    check("x0_dout", rs_dout, 64'h0);
    check("x0_busy", {62'h0, rs_busy}, 64'h0);
    check("x0_count", {58'h0, busy_count}, 64'h0);

    // scoreboard: issue x7 then x9
    idle();
    issue_en = 1'b1; issue_rd = 5'd7;
    tick();
    check("iss7_count", {58'h0, busy_count}, 64'h1);
    issue_rd = 5'd9;
    tick();
    check("iss9_count", {58'h0, busy_count}, 64'h2);
    idle();
    rd_ports(2'b01, 5'd7, 5'd0);
    tick();
    check("x7_busy", {62'h0, rs_busy}, 64'h1);
    check("x7_count", {58'h0, busy_count}, 64'h2);

    // write x7 and re-issue x7 together: set wins
    idle();
    rd_en = 1'b1; rd = 5'd7; rd_din = 32'h55;
    issue_en = 1'b1; issue_rd = 5'd7;
    tick();
    check("setwin_count", {58'h0, busy_count}, 64'h2);
    idle();
    rd_ports(2'b11, 5'd7, 5'd9);
    tick();
    check("x7_data", rs_dout, 64'h00000000_00000055);
    check("x7x9_busy", {62'h0, rs_busy}, 64'h3);

    // same-cycle issue not visible to a read of that register
    idle();
    issue_en = 1'b1; issue_rd = 5'd8;
    rd_ports(2'b01, 5'd8, 5'd0);
    tick();
    check("iss8_busy", {62'h0, rs_busy}, 64'h2);
    check("iss8_valid", {62'h0, rs_valid}, 64'h1);
    check("iss8_count", {58'h0, busy_count}, 64'h3);

    // write to busy x9 clears it and masks busy on the same-cycle read
    idle();
    rd_en = 1'b1; rd = 5'd9; rd_din = 32'h99;
    rd_ports(2'b11, 5'd8, 5'd9);
    tick();
    check("x9_dout", rs_dout, 64'h00000099_00000000);
    check("x9_busy", {62'h0, rs_busy}, 64'h1);
    check("x9_count", {58'h0, busy_count}, 64'h2);

    // write to non-busy x10 plus re-issue of busy x7: count unchanged
    idle();
    rd_en = 1'b1; rd = 5'd10; rd_din = 32'h10;
    issue_en = 1'b1; issue_rd = 5'd7;
    tick();
    check("nowrap_count", {58'h0, busy_count}, 64'h2);

    // issue + write x4 with port1 reading x4
    idle();
    issue_en = 1'b1; issue_rd = 5'd4;
    rd_en = 1'b1; rd = 5'd4; rd_din = 32'hA5;
    rd_ports(2'b10, 5'd0, 5'd4);
    tick();
    check("x4_dout", rs_dout, 64'h000000A5_00000000);
    check("x4_busy", {62'h0, rs_busy}, 64'h1);
    check("x4_count", {58'h0, busy_count}, 64'h3);
    idle();
    rd_ports(2'b11, 5'd10, 5'd4);
    tick();
    check("x4_reread", rs_dout, 64'h000000A5_00000010);
    check("x4_busy2", {62'h0, rs_busy}, 64'h2);

    // no reads: outputs hold, valid drops
    idle();
    tick();
    check("hold_dout", rs_dout, 64'h000000A5_00000010);
    check("hold_busy", {62'h0, rs_busy}, 64'h2);
    check("hold_valid", {62'h0, rs_valid}, 64'h0);

    // write x2, then async reset mid-cycle with another write in flight
    rd_en = 1'b1; rd = 5'd2; rd_din = 32'h77;
    tick();
    rd_din = 32'h88;
    rd_ports(2'b11, 5'd2, 5'd4);
    #2;
    rst = 1'b1;
    #1;
    check("arst_dout", rs_dout, 64'h0);
    check("arst_valid", {62'h0, rs_valid}, 64'h0);
    check("arst_busy", {62'h0, rs_busy}, 64'h0);
    check("arst_count", {58'h0, busy_count}, 64'h0);
    idle();
    #10;
    rst = 1'b0;
    rd_ports(2'b11, 5'd2, 5'd7);
    tick();
    check("post_dout", rs_dout, 64'h0);
    check("post_valid", {62'h0, rs_valid}, 64'h3);
    check("post_busy", {62'h0, rs_busy}, 64'h0);
    check("post_count", {58'h0, busy_count}, 64'h0);

    idle();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
